// File: rtl/sti_arb2_pkg.sv
// Shared definitions for the two-master STI arbiter: default widths,
// arbiter state encoding and master ids.
package sti_arb2_pkg;

  localparam int STI_AW = 16;
  localparam int STI_DW = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY0 = 2'd1,
    ST_BUSY1 = 2'd2
  } st_e;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

endpackage

// File: rtl/sti_arb2_slot.sv
// One master's request slot: captures a single-cycle STI request, tracks
// pending/in-flight status and flags a request that arrives while occupied.
module sti_slot #(
  parameter int AW = 16,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          init_txn,
  input  logic          wtxn,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  input  logic          grant,
  input  logic          done,
  output logic          pend,
  output logic          inflight,
  output logic          q_wtxn,
  output logic [AW-1:0] q_addr,
  output logic [DW-1:0] q_wdata,
  output logic          dbl
);

  logic busy, take;

  // A completing slot is free again in its rdy cycle, so a new request
  // arriving then is captured rather than flagged.
  always_comb begin
    busy = pend | inflight;
    take = init_txn & (~busy | done);
    dbl  = init_txn & busy & ~done;
  end

  // Capture register and pend -> inflight -> empty lifecycle.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      pend     <= 1'b0;
      inflight <= 1'b0;
      q_wtxn   <= 1'b0;
      q_addr   <= '0;
      q_wdata  <= '0;
    end else if (take) begin
      pend     <= 1'b1;
      inflight <= 1'b0;
      q_wtxn   <= wtxn;
      q_addr   <= addr;
      q_wdata  <= wdata;
    end else begin
      if (grant) begin
        pend     <= 1'b0;
        inflight <= 1'b1;
      end
      if (done) inflight <= 1'b0;
    end
  end

endmodule

// File: rtl/sti_arb2.sv
// Two-master to one-slave STI arbiter. Requests are latched per master,
// one is granted and replayed to the slave, and the completion is routed
// back to the owning master only.
module sti_arb2
  import sti_arb2_pkg::*;
#(
  parameter int AW        = STI_AW,
  parameter int DW        = STI_DW,
  parameter int FIXED_PRI = 0
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          m0_init_txn,
  input  logic          m0_wtxn,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rdy,
  input  logic          m1_init_txn,
  input  logic          m1_wtxn,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rdy,
  output logic          s_init_txn,
  output logic          s_wtxn,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rdy,
  output logic          err
);

  st_e st, st_nxt;
  logic last;

  logic [1:0]         init, wtxn, pend, inflight, q_wtxn, dbl, grant, done;
  logic [1:0][AW-1:0] addr, q_addr;
  logic [1:0][DW-1:0] wdata, q_wdata;
  logic               gnt_id, sel, drive;

  assign init  = {m1_init_txn, m0_init_txn};
  assign wtxn  = {m1_wtxn, m0_wtxn};
  assign addr  = {m1_addr, m0_addr};
  assign wdata = {m1_wdata, m0_wdata};

  for (genvar i = 0; i < 2; i++) begin : g_slot
    sti_slot #(.AW(AW), .DW(DW)) u_slot (
      .clk      (clk),
      .arst_n   (arst_n),
      .init_txn (init[i]),
      .wtxn     (wtxn[i]),
      .addr     (addr[i]),
      .wdata    (wdata[i]),
      .grant    (grant[i]),
      .done     (done[i]),
      .pend     (pend[i]),
      .inflight (inflight[i]),
      .q_wtxn   (q_wtxn[i]),
      .q_addr   (q_addr[i]),
      .q_wdata  (q_wdata[i]),
      .dbl      (dbl[i])
    );
  end

  // Arbitration and transaction sequencing; the slave bus is driven from
  // the granted slot in the grant cycle and from the owner while busy.
  always_comb begin
    st_nxt     = st;
    grant      = '0;
    done       = '0;
    s_init_txn = 1'b0;
    sel        = MST_M0;
    drive      = 1'b0;
    gnt_id     = MST_M0;
    if (pend[0] && pend[1]) gnt_id = (FIXED_PRI != 0) ? MST_M0 : ~last;
    else if (pend[1])       gnt_id = MST_M1;
    case (st)
      ST_IDLE: begin
        if (|pend) begin
          s_init_txn     = 1'b1;
          sel            = gnt_id;
          drive          = 1'b1;
          grant[gnt_id]  = 1'b1;
          st_nxt         = gnt_id ? ST_BUSY1 : ST_BUSY0;
        end
      end
      ST_BUSY0, ST_BUSY1: begin
        sel   = (st == ST_BUSY1);
        drive = 1'b1;
        if (s_rdy) begin
          done[sel] = 1'b1;
          st_nxt    = ST_IDLE;
        end
      end
      default: st_nxt = ST_IDLE;
    endcase
  end

  assign s_wtxn   = drive & q_wtxn[sel];
  assign s_addr   = drive ? q_addr[sel]  : '0;
  assign s_wdata  = drive ? q_wdata[sel] : '0;
  assign m0_rdy   = done[0];
  assign m1_rdy   = done[1];
  assign m0_rdata = done[0] ? s_rdata : '0;
  assign m1_rdata = done[1] ? s_rdata : '0;

  // State, round-robin pointer (M1 after reset so M0 wins the first tie)
  // and sticky double-issue flag.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      st   <= ST_IDLE;
      last <= MST_M1;
      err  <= 1'b0;
    end else begin
      st <= st_nxt;
      if (|grant) last <= gnt_id;
      if (|dbl)   err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sti_arb2.sv
// Bench for sti_arb2: one round-robin and one fixed-priority instance, each
// with its own stimulus, checked every cycle against a transaction-level model.
module tb_sti_arb2;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic        m0_i[2], m0_w[2], m1_i[2], m1_w[2], s_r[2];
  logic [15:0] m0_a[2], m0_d[2], m1_a[2], m1_d[2], s_rd[2];
  logic [15:0] m0_q[2], m1_q[2], s_a[2], s_d[2];
  logic        m0_y[2], m1_y[2], s_i[2], s_w[2], er[2];

  sti_arb2 #(.AW(16), .DW(16), .FIXED_PRI(0)) dut (
    .clk(clk), .arst_n(arst_n),
    .m0_init_txn(m0_i[0]), .m0_wtxn(m0_w[0]), .m0_addr(m0_a[0]), .m0_wdata(m0_d[0]),
    .m0_rdata(m0_q[0]), .m0_rdy(m0_y[0]),
    .m1_init_txn(m1_i[0]), .m1_wtxn(m1_w[0]), .m1_addr(m1_a[0]), .m1_wdata(m1_d[0]),
    .m1_rdata(m1_q[0]), .m1_rdy(m1_y[0]),
    .s_init_txn(s_i[0]), .s_wtxn(s_w[0]), .s_addr(s_a[0]), .s_wdata(s_d[0]),
    .s_rdata(s_rd[0]), .s_rdy(s_r[0]), .err(er[0]));

  sti_arb2 #(.AW(16), .DW(16), .FIXED_PRI(1)) dutf (
    .clk(clk), .arst_n(arst_n),
    .m0_init_txn(m0_i[1]), .m0_wtxn(m0_w[1]), .m0_addr(m0_a[1]), .m0_wdata(m0_d[1]),
    .m0_rdata(m0_q[1]), .m0_rdy(m0_y[1]),
    .m1_init_txn(m1_i[1]), .m1_wtxn(m1_w[1]), .m1_addr(m1_a[1]), .m1_wdata(m1_d[1]),
    .m1_rdata(m1_q[1]), .m1_rdy(m1_y[1]),
    .s_init_txn(s_i[1]), .s_wtxn(s_w[1]), .s_addr(s_a[1]), .s_wdata(s_d[1]),
    .s_rdata(s_rd[1]), .s_rdy(s_r[1]), .err(er[1]));

  int errors = 0;
  int checks = 0;

  // Reference model: per instance, which master owns the slave (-1 = none),
  // which requests wait, their contents, who was served last, sticky error.
  bit          pend[2][2];
  int          own[2];
  int          lst[2];
  bit          e[2];
  bit          rw[2][2];
  logic [15:0] ra[2][2], rdd[2][2];

  task automatic chk1(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int d = 0; d < 2; d++) begin
      own[d] = -1; lst[d] = 1; e[d] = 1'b0;
      for (int x = 0; x < 2; x++) begin
        pend[d][x] = 1'b0; rw[d][x] = 1'b0; ra[d][x] = '0; rdd[d][x] = '0;
      end
    end
  endtask

  task automatic req(int d, int m, bit w, logic [15:0] a, logic [15:0] wd);
    if (m == 0) begin m0_i[d] = 1'b1; m0_w[d] = w; m0_a[d] = a; m0_d[d] = wd; end
    else        begin m1_i[d] = 1'b1; m1_w[d] = w; m1_a[d] = a; m1_d[d] = wd; end
  endtask

  // One clock cycle: compare all outputs with the model mid-cycle, advance
  // the model at the edge, then drop the single-cycle pulses.
  task automatic tick();
    int g[2];
    bit dn[2];
    int src;
    bit ew;
    logic [15:0] ea, ed;
    bit occ[2], fr[2], mi;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      g[d] = -1;
      if (own[d] < 0) begin
        if (pend[d][0] && pend[d][1]) g[d] = (d == 1) ? 0 : ((lst[d] == 1) ? 0 : 1);
        else if (pend[d][0]) g[d] = 0;
        else if (pend[d][1]) g[d] = 1;
      end
      src = (own[d] >= 0) ? own[d] : g[d];
      ew = 1'b0; ea = '0; ed = '0;
      if (src >= 0) begin ew = rw[d][src]; ea = ra[d][src]; ed = rdd[d][src]; end
      dn[d] = (own[d] >= 0) && s_r[d];
      chk1 ($sformatf("d%0d s_init_txn", d), s_i[d], g[d] >= 0);
      chk1 ($sformatf("d%0d s_wtxn", d), s_w[d], ew);
      chk16($sformatf("d%0d s_addr", d), s_a[d], ea);
      chk16($sformatf("d%0d s_wdata", d), s_d[d], ed);
      chk1 ($sformatf("d%0d m0_rdy", d), m0_y[d], dn[d] && own[d] == 0);
      chk1 ($sformatf("d%0d m1_rdy", d), m1_y[d], dn[d] && own[d] == 1);
      chk16($sformatf("d%0d m0_rdata", d), m0_q[d], (dn[d] && own[d] == 0) ? s_rd[d] : 16'h0);
      chk16($sformatf("d%0d m1_rdata", d), m1_q[d], (dn[d] && own[d] == 1) ? s_rd[d] : 16'h0);
      chk1 ($sformatf("d%0d err", d), er[d], e[d]);
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      for (int x = 0; x < 2; x++) begin
        occ[x] = pend[d][x] || own[d] == x;
        fr[x]  = dn[d] && own[d] == x;
      end
      if (g[d] >= 0) begin pend[d][g[d]] = 1'b0; own[d] = g[d]; lst[d] = g[d]; end
      else if (dn[d]) own[d] = -1;
      for (int x = 0; x < 2; x++) begin
        mi = (x == 0) ? m0_i[d] : m1_i[d];
        if (mi) begin
          if (!occ[x] || fr[x]) begin
            pend[d][x] = 1'b1;
            rw[d][x]   = (x == 0) ? m0_w[d] : m1_w[d];
            ra[d][x]   = (x == 0) ? m0_a[d] : m1_a[d];
            rdd[d][x]  = (x == 0) ? m0_d[d] : m1_d[d];
          end else e[d] = 1'b1;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      m0_i[d] = 1'b0; m1_i[d] = 1'b0; s_r[d] = 1'b0;
    end
  endtask

  // Reset both instances; outputs must be 0 while in reset even with a
  // completion pulse on the slave side.
  task automatic do_reset();
    arst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      m0_i[d] = 1'b0; m1_i[d] = 1'b0; m0_w[d] = 1'b0; m1_w[d] = 1'b0;
      m0_a[d] = '0; m1_a[d] = '0; m0_d[d] = '0; m1_d[d] = '0;
      s_r[d] = 1'b1; s_rd[d] = 16'hFFFF;
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk1 ("rst s_init_txn", s_i[d], 1'b0);
      chk1 ("rst s_wtxn", s_w[d], 1'b0);
      chk16("rst s_addr", s_a[d], 16'h0);
      chk16("rst s_wdata", s_d[d], 16'h0);
      chk1 ("rst m0_rdy", m0_y[d], 1'b0);
      chk1 ("rst m1_rdy", m1_y[d], 1'b0);
      chk16("rst m0_rdata", m0_q[d], 16'h0);
      chk16("rst m1_rdata", m1_q[d], 16'h0);
      chk1 ("rst err", er[d], 1'b0);
    end
    mreset();
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) s_r[d] = 1'b0;
    arst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cur;
    do_reset();

    // M0 read 0x3000, slave answers two cycles after the grant
    req(0, 0, 1'b0, 16'h3000, 16'h0);
    tick();
    #1;
    chk1 ("t1 s_init", s_i[0], 1'b1);
    chk16("t1 s_addr", s_a[0], 16'h3000);
    chk1 ("t1 s_wtxn", s_w[0], 1'b0);
    tick();
    tick();
    s_r[0] = 1'b1; s_rd[0] = 16'hBEEF;
    #1;
    chk1 ("t1 m0_rdy", m0_y[0], 1'b1);
    chk16("t1 m0_rdata", m0_q[0], 16'hBEEF);
    chk1 ("t1 m1_rdy", m1_y[0], 1'b0);
    tick();
    tick();

    // Simultaneous requests after reset; then every tie alternates
    do_reset();
    req(0, 0, 1'b1, 16'h4000, 16'h1234);
    req(0, 1, 1'b0, 16'h5000, 16'h0);
    tick();
    #1;
    chk1 ("t2 first s_init", s_i[0], 1'b1);
    chk16("t2 first s_addr", s_a[0], 16'h4000);
    chk1 ("t2 first s_wtxn", s_w[0], 1'b1);
    chk16("t2 first s_wdata", s_d[0], 16'h1234);
    tick();
    tick();
    s_r[0] = 1'b1; s_rd[0] = 16'h0;
    tick();
    cur = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1 ("t2 tie s_init", s_i[0], 1'b1);
      chk16("t2 tie s_addr", s_a[0], (cur == 1) ? 16'h5000 : 16'h4000);
      tick();
      if (k == 0) req(0, 0, 1'b1, 16'h4000, 16'h1234);
      tick();
      s_r[0] = 1'b1; s_rd[0] = 16'(16'hA000 + k);
      req(0, cur, cur == 0, (cur == 1) ? 16'h5000 : 16'h4000, 16'h1234);
      tick();
      cur = 1 - cur;
    end

    // Fixed priority: M0 keeps re-requesting and wins every tie
    do_reset();
    req(1, 0, 1'b1, 16'h4000, 16'h1234);
    req(1, 1, 1'b0, 16'h5000, 16'h0);
    tick();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk1 ("t3 s_init", s_i[1], 1'b1);
      chk16("t3 M0 wins", s_a[1], 16'h4000);
      tick();
      tick();
      s_r[1] = 1'b1; s_rd[1] = 16'h0;
      if (k < 3) req(1, 0, 1'b1, 16'h4000, 16'h1234);
      tick();
    end
    #1;
    chk1 ("t3 M1 s_init", s_i[1], 1'b1);
    chk16("t3 M1 served", s_a[1], 16'h5000);
    tick();

    // Double issue while M1 is in flight
    do_reset();
    req(0, 1, 1'b0, 16'h5000, 16'h0);
    tick();
    #1;
    chk1("t4 grant", s_i[0], 1'b1);
    tick();
    req(0, 1, 1'b1, 16'h6000, 16'h0077);
    tick();
    #1;
    chk1 ("t4 err", er[0], 1'b1);
    chk16("t4 s_addr held", s_a[0], 16'h5000);
    chk1 ("t4 no reissue", s_i[0], 1'b0);
    tick();
    s_r[0] = 1'b1; s_rd[0] = 16'h0;
    tick();
    #1;
    chk1 ("t4 no 2nd s_init", s_i[0], 1'b0);
    chk16("t4 idle s_addr", s_a[0], 16'h0);
    tick();

    // Stray completion while idle
    do_reset();
    s_r[0] = 1'b1; s_rd[0] = 16'h1111;
    #1;
    chk1("t5 m0_rdy", m0_y[0], 1'b0);
    chk1("t5 m1_rdy", m1_y[0], 1'b0);
    tick();
    #1;
    chk1("t5 err", er[0], 1'b0);
    req(0, 0, 1'b0, 16'h2000, 16'h0);
    tick();
    #1;
    chk1 ("t5 still idle", s_i[0], 1'b1);
    chk16("t5 s_addr", s_a[0], 16'h2000);
    tick();

    // Reset during BUSY1, late completion, then a tie
    do_reset();
    req(0, 1, 1'b0, 16'h7000, 16'h0);
    tick();
    tick();
    tick();
    do_reset();
    s_r[0] = 1'b1; s_rd[0] = 16'h2222;
    #1;
    chk1 ("t6 late m1_rdy", m1_y[0], 1'b0);
    chk16("t6 late m1_rdata", m1_q[0], 16'h0);
    tick();
    req(0, 0, 1'b0, 16'h4000, 16'h0);
    req(0, 1, 1'b0, 16'h5000, 16'h0);
    tick();
    #1;
    chk1 ("t6 tie s_init", s_i[0], 1'b1);
    chk16("t6 M0 wins", s_a[0], 16'h4000);
    tick();

    // Random traffic on both instances, including stray and double pulses
    do_reset();
    for (int n = 0; n < 400; n++) begin
      if (n == 200) do_reset();
      for (int d = 0; d < 2; d++) begin
        m0_i[d] = ($urandom_range(3) == 0);
        m0_w[d] = $urandom_range(1) == 1;
        m0_a[d] = 16'($urandom);
        m0_d[d] = 16'($urandom);
        m1_i[d] = ($urandom_range(3) == 0);
        m1_w[d] = $urandom_range(1) == 1;
        m1_a[d] = 16'($urandom);
        m1_d[d] = 16'($urandom);
        s_r[d]  = ($urandom_range(2) == 0);
        s_rd[d] = 16'($urandom);
      end
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
